// File: rtl/coin_vend_ctrl.sv
// rtl/coin_vend_ctrl.sv - coin-operated vend controller: credit, dispense pulse, change strobe.
// Optional refund input enabled by defining COIN_VEND_CANCEL_EN.
module coin_vend_ctrl #(
    parameter int PRICE       = 10,
    parameter int COIN_W      = 4,
    parameter int SUM_W       = 5,
    parameter int DISP_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
`ifdef COIN_VEND_CANCEL_EN
    input  logic              cancel,
`endif
    input  logic              coin_valid,
    input  logic [COIN_W-1:0] coin,
    output logic              despencer,
    output logic              change_valid,
    output logic [SUM_W-1:0]  change,
    output logic              coin_reject,
    output logic              LED_Yellow,
    output logic              LED_Green
);

    localparam int CNT_W = $clog2(DISP_CYCLES + 1);
    localparam logic [SUM_W:0] PRICE_W = (SUM_W + 1)'(PRICE);

    if ((PRICE < 1) || (DISP_CYCLES < 1) ||
        ((PRICE - 1) + (2 ** COIN_W - 1) > (2 ** SUM_W - 1))) begin : g_param_check
        $error("coin_vend_ctrl: illegal PRICE/COIN_W/SUM_W/DISP_CYCLES combination");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [SUM_W-1:0]   excess_q, excess_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               coin_reject_q, coin_reject_d;

    logic               cancel_req;
    logic               offered;
    logic [SUM_W:0]     total;

`ifdef COIN_VEND_CANCEL_EN
    assign cancel_req = cancel;
`else
    assign cancel_req = 1'b0;
`endif

    assign offered = coin_valid && (coin != '0);
    // One spare bit so the price comparison never sees a wrapped sum.
    assign total   = {1'b0, sum_q} + (SUM_W + 1)'(coin);

    always_comb begin
        state_d       = state_q;
        sum_d         = sum_q;
        excess_d      = excess_q;
        cnt_d         = cnt_q;
        coin_reject_d = 1'b0;
        case (state_q)
            IDLE, COLLECT: begin
                if ((state_q == COLLECT) && cancel_req) begin
                    // Refund only the credit held before this cycle.
                    excess_d      = sum_q;
                    sum_d         = '0;
                    state_d       = CHANGE;
                    coin_reject_d = offered;
                end else if (offered) begin
                    if (total >= PRICE_W) begin
                        excess_d = SUM_W'(total - PRICE_W);
                        sum_d    = '0;
                        cnt_d    = CNT_W'(DISP_CYCLES);
                        state_d  = DISPENSE;
                    end else begin
                        sum_d   = SUM_W'(total);
                        state_d = COLLECT;
                    end
                end
            end
            DISPENSE: begin
                coin_reject_d = offered;
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = (excess_q != '0) ? CHANGE : IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CHANGE: begin
                coin_reject_d = offered;
                excess_d      = '0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            sum_q         <= '0;
            excess_q      <= '0;
            cnt_q         <= '0;
            coin_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sum_q         <= sum_d;
            excess_q      <= excess_d;
            cnt_q         <= cnt_d;
            coin_reject_q <= coin_reject_d;
        end
    end

    assign despencer    = (state_q == DISPENSE);
    assign LED_Yellow   = (state_q == DISPENSE);
    assign LED_Green    = (state_q == IDLE);
    assign change_valid = (state_q == CHANGE);
    assign change       = (state_q == CHANGE) ? excess_q : '0;
    assign coin_reject  = coin_reject_q;

endmodule
